// File: rtl/data_scratchpad.sv
// Word-organised scratchpad with byte/half/word loads and stores and a fixed response latency.
// Define SCRATCHPAD_ERR_EN to add a sticky err_o flag for dropped and misaligned requests.
module data_scratchpad #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dc_addr_i,
    input  logic [31:0] dc_data_i,
    input  logic [2:0]  dc_op_i,
    input  logic        dc_valid_i,
    output logic [31:0] dc_data_o,
    output logic        dc_valid_o
`ifdef SCRATCHPAD_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [AW+1:0]   addr_q;
    logic [31:0]     data_q;
    logic [2:0]      op_q;
    logic            accept;
    logic            fire;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   idx;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic [31:0]     wr_data;
    logic [3:0]      wr_be;

    // Address bits above the array are ignored so accesses wrap around.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^dc_addr_i[31:AW+2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dc_valid_i) state_next = BUSY;
            BUSY:    if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && dc_valid_i;
        fire   = (state == BUSY) && (count == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (accept) begin
            count <= CW'(LATENCY - 1);
        end else if ((state == BUSY) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q <= dc_addr_i[AW+1:0];
            data_q <= dc_data_i;
            op_q   <= dc_op_i;
        end
    end

    always_comb begin
        idx      = addr_q[AW+1:2];
        rd_word  = mem[idx];
        rd_shift = rd_word >> {addr_q[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = '0;
        case (op_q)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LW:   load_val = rd_word;
            OP_LBU:  load_val = {24'h0, rd_byte};
            OP_LHU:  load_val = {16'h0, rd_half};
            default: load_val = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = data_q;
        case (op_q)
            OP_SB: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{data_q[7:0]}};
            end
            OP_SH: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_q[15:0]}};
            end
            OP_SW: begin
                wr_be   = 4'b1111;
                wr_data = data_q;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = data_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (fire && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dc_valid_o <= 1'b0;
            dc_data_o  <= '0;
        end else begin
            dc_valid_o <= fire;
            if (fire) begin
                dc_data_o <= load_val;
            end
        end
    end

`ifdef SCRATCHPAD_ERR_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (dc_op_i)
            OP_LH, OP_LHU, OP_SH: misaligned = dc_addr_i[0];
            OP_LW, OP_SW:         misaligned = (dc_addr_i[1:0] != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (((state == BUSY) && dc_valid_i) || (accept && misaligned)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_scratchpad.sv
// Randomised self-checking bench for data_scratchpad against a byte-array reference memory.
// Also checks err_o when built with SCRATCHPAD_ERR_EN.
module tb_data_scratchpad;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] dc_addr_i;
    logic [31:0] dc_data_i;
    logic [2:0]  dc_op_i;
    logic        dc_valid_i;
    logic [31:0] dc_data_o;
    logic        dc_valid_o;
`ifdef SCRATCHPAD_ERR_EN
    logic        err_o;
`endif

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    logic [7:0] mref [DEPTH*4];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dc_valid_o === 1'b1) pulse_cnt++;
    end

    data_scratchpad #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .dc_addr_i  (dc_addr_i),
        .dc_data_i  (dc_data_i),
        .dc_op_i    (dc_op_i),
        .dc_valid_i (dc_valid_i),
        .dc_data_o  (dc_data_o),
        .dc_valid_o (dc_valid_o)
`ifdef SCRATCHPAD_ERR_EN
        ,
        .err_o      (err_o)
`endif
    );

    function automatic int base_of(input logic [31:0] a);
        return int'(a[AW+1:2]) * 4;
    endfunction

    // Result the requester should see: loads from the byte image, stores answer zero.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] w;
        b  = base_of(a);
        by = mref[b + int'(a[1:0])];
        hw = a[1] ? {mref[b+3], mref[b+2]} : {mref[b+1], mref[b]};
        w  = {mref[b+3], mref[b+2], mref[b+1], mref[b]};
        case (op)
            OP_LB:   return {{24{by[7]}}, by};
            OP_LH:   return {{16{hw[15]}}, hw};
            OP_LW:   return w;
            OP_LBU:  return {24'h0, by};
            OP_LHU:  return {16'h0, hw};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int b;
        int h;
        b = base_of(a);
        h = a[1] ? 2 : 0;
        case (op)
            OP_SB: mref[b + int'(a[1:0])] = d[7:0];
            OP_SH: begin
                mref[b+h]   = d[7:0];
                mref[b+h+1] = d[15:8];
            end
            OP_SW: begin
                mref[b]   = d[7:0];
                mref[b+1] = d[15:8];
                mref[b+2] = d[23:16];
                mref[b+3] = d[31:24];
            end
            default: ;
        endcase
    endtask

    // One request; reports cycles from acceptance edge to first response and pulses seen.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int lat, output int npulse);
        @(negedge clk);
        dc_op_i    = op;
        dc_addr_i  = a;
        dc_data_i  = d;
        dc_valid_i = 1'b1;
        @(negedge clk);
        dc_valid_i = 1'b0;
        lat    = -1;
        npulse = 0;
        rdata  = 32'hx;
        for (int k = 0; k <= LAT + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (dc_valid_o === 1'b1) begin
                npulse++;
                if (lat < 0) begin
                    lat   = k;
                    rdata = dc_data_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        dc_valid_i = 1'b0;
        dc_op_i    = OP_LW;
        dc_addr_i  = '0;
        dc_data_i  = '0;
        repeat (3) @(negedge clk);
        total++;
        if (dc_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid got=%b want=0", dc_valid_o);
        end
        total++;
        if (dc_data_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=00000000", dc_data_o);
        end
`ifdef SCRATCHPAD_ERR_EN
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_err got=%b want=0", err_o);
        end
`endif
        rst_i = 1'b0;
    endtask

    task automatic init_region();
        logic [31:0] r;
        logic [31:0] d;
        int l;
        int n;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            do_req(OP_SW, 32'(w * 4), d, r, l, n);
            model_store(OP_SW, 32'(w * 4), d);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [11] = '{OP_SW, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU,
                                   OP_SB, OP_LW, OP_SW, OP_LW, OP_LW};
        logic [31:0] adrs [11] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h10, 32'h12,
                                   32'h11, 32'h10, 32'h1004, 32'h4, 32'h1010};
        logic [31:0] dats [11] = '{32'hDEADBEEF, 0, 0, 0, 0, 0,
                                   32'h55, 0, 32'hA5A5A5A5, 0, 0};
        logic [31:0] exps [11] = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE,
                                   32'hFFFFBEEF, 32'h0000DEAD, 32'h0, 32'hDEAD55EF,
                                   32'h0, 32'hA5A5A5A5, 32'hDEAD55EF};
        logic [31:0] r;
        int l;
        int n;
        for (int i = 0; i < 11; i++) begin
            do_req(ops[i], adrs[i], dats[i], r, l, n);
            model_store(ops[i], adrs[i], dats[i]);
            total++;
            if (l != LAT || n != 1) begin
                bad++;
                $display("[TB] FAIL directed_timing[%0d] got lat=%0d pulses=%0d want lat=%0d pulses=1",
                         i, l, n, LAT);
            end
            total++;
            if (r !== exps[i]) begin
                bad++;
                $display("[TB] FAIL directed_data[%0d] got=%h want=%h", i, r, exps[i]);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (dc_data_o !== 32'hDEAD55EF) begin
            bad++;
            $display("[TB] FAIL hold_data got=%h want=DEAD55EF", dc_data_o);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] r;
        int l;
        int n;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2)
                 | 32'($urandom_range(0, 3));
            d  = $urandom;
            e  = model_load(op, a);
            do_req(op, a, d, r, l, n);
            model_store(op, a, d);
            total++;
            if (l != LAT || n != 1) begin
                bad++;
                $display("[TB] FAIL random_timing[%0d] got lat=%0d pulses=%0d want lat=%0d pulses=1",
                         i, l, n, LAT);
            end
            total++;
            if (r !== e) begin
                bad++;
                $display("[TB] FAIL random_data[%0d] op=%0d addr=%h got=%h want=%h", i, op, a, r, e);
            end
        end
    endtask

    task automatic test_drop();
        int start;
        logic [31:0] r;
        logic [31:0] e;
        int l;
        int n;
        for (int d = 1; d <= LAT; d++) begin
            start = pulse_cnt;
            e     = model_load(OP_LW, 32'h1C);
            @(negedge clk);
            dc_op_i    = OP_LW;
            dc_addr_i  = 32'h8;
            dc_valid_i = 1'b1;
            @(negedge clk);
            dc_valid_i = 1'b0;
            for (int j = 1; j < d; j++) @(negedge clk);
            dc_op_i    = OP_SW;
            dc_addr_i  = 32'h1C;
            dc_data_i  = ~e;
            dc_valid_i = 1'b1;
            @(negedge clk);
            dc_valid_i = 1'b0;
            repeat (LAT + 5) @(negedge clk);
            total++;
            if (pulse_cnt - start != 1) begin
                bad++;
                $display("[TB] FAIL drop_pulses[%0d] got=%0d want=1", d, pulse_cnt - start);
            end
`ifdef SCRATCHPAD_ERR_EN
            total++;
            if (err_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL drop_err[%0d] got=%b want=1", d, err_o);
            end
`endif
            do_req(OP_LW, 32'h1C, 32'h0, r, l, n);
            total++;
            if (r !== e) begin
                bad++;
                $display("[TB] FAIL drop_mem[%0d] got=%h want=%h", d, r, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int start;
        logic [31:0] e;
        logic [31:0] r;
        int l;
        int n;
        e = model_load(OP_LW, 32'h20);
        if (e == 32'h12345678) begin
            e = 32'h0BADF00D;
            do_req(OP_SW, 32'h20, e, r, l, n);
            model_store(OP_SW, 32'h20, e);
        end
        start = pulse_cnt;
        @(negedge clk);
        dc_op_i    = OP_SW;
        dc_addr_i  = 32'h20;
        dc_data_i  = 32'h12345678;
        dc_valid_i = 1'b1;
        @(negedge clk);
        dc_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        total++;
        if (dc_data_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid_data got=%h want=00000000", dc_data_o);
        end
`ifdef SCRATCHPAD_ERR_EN
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_err got=%b want=0", err_o);
        end
`endif
        repeat (LAT + 4) @(negedge clk);
        total++;
        if (pulse_cnt != start) begin
            bad++;
            $display("[TB] FAIL reset_mid_pulses got=%0d want=0", pulse_cnt - start);
        end
        do_req(OP_LW, 32'h20, 32'h0, r, l, n);
        total++;
        if (r !== e) begin
            bad++;
            $display("[TB] FAIL reset_mid_mem got=%h want=%h", r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e2;
        logic [31:0] got;
        int seen;
        int lat;
        e2 = model_load(OP_LW, 32'hC);
        @(negedge clk);
        dc_op_i    = OP_LW;
        dc_addr_i  = 32'h8;
        dc_valid_i = 1'b1;
        @(negedge clk);
        dc_valid_i = 1'b0;
        seen = 0;
        for (int k = 0; k <= LAT + 4 && seen == 0; k++) begin
            if (k > 0) @(negedge clk);
            if (dc_valid_o === 1'b1) seen = 1;
        end
        total++;
        if (seen == 0) begin
            bad++;
            $display("[TB] FAIL b2b_first got=no_response want=response");
        end
        dc_op_i    = OP_LW;
        dc_addr_i  = 32'hC;
        dc_valid_i = 1'b1;
        @(negedge clk);
        dc_valid_i = 1'b0;
        total++;
        if (dc_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_single_pulse got=%b want=0", dc_valid_o);
        end
        lat = -1;
        got = 32'hx;
        for (int k = 0; k <= LAT + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (dc_valid_o === 1'b1 && lat < 0) begin
                lat = k;
                got = dc_data_o;
            end
        end
        total++;
        if (lat != LAT) begin
            bad++;
            $display("[TB] FAIL b2b_latency got=%0d want=%0d", lat, LAT);
        end
        total++;
        if (got !== e2) begin
            bad++;
            $display("[TB] FAIL b2b_data got=%h want=%h", got, e2);
        end
    endtask

    initial begin
        test_reset();
        init_region();
        test_directed();
        test_random();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_scratchpad.md
DATA_SCRATCHPAD -- requirements
Module: data_scratchpad

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 1024, number of 32-bit words (power of two); LATENCY, default 2, cycles from request acceptance to response (>=1).
REQ-002 clk_i  input  1  sole clock; all logic on posedge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 dc_addr_i  input  32  byte address of request.
REQ-005 dc_data_i  input  32  store data (low bits used for byte/half stores).
REQ-006 dc_op_i  input  3  operation code per REQ-011.
REQ-007 dc_valid_i  input  1  request strobe; single-cycle pulse from requester.
REQ-008 dc_data_o  output  32  load result, registered.
REQ-009 dc_valid_o  output  1  response strobe; exactly one single-cycle pulse per accepted request, loads and stores alike.

Function
REQ-010 Storage SHALL be DEPTH_WORDS x 32-bit little-endian; word index = dc_addr_i[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around, no fault).
REQ-011 dc_op_i SHALL decode: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-012 Byte ops SHALL select lane addr[1:0]; half ops SHALL select lane addr[1] and ignore addr[0]; word ops SHALL ignore addr[1:0].
REQ-013 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend to 32 bits; LW returns the full word.
REQ-014 SB/SH/SW SHALL write only the selected byte lanes, leaving other lanes unchanged; stores SHALL drive dc_data_o = 0 in the response cycle.
REQ-015 FSM states SHALL be IDLE and BUSY; request accepted only when state = IDLE and dc_valid_i = 1, capturing addr, data and op into registers.
REQ-016 On acceptance, state SHALL move to BUSY and a latency counter SHALL load LATENCY-1.
REQ-017 In BUSY the counter SHALL decrement each cycle; when it reaches 0, the memory access (read or write) SHALL be performed, dc_valid_o SHALL be 1 for that cycle's result at the next edge, and state SHALL return to IDLE.
REQ-018 dc_valid_o SHALL assert exactly LATENCY cycles after the acceptance edge and SHALL deassert the following cycle.
REQ-019 dc_data_o SHALL hold its last value when dc_valid_o = 0.
REQ-020 dc_valid_i asserted while BUSY (including the response cycle) SHALL be dropped: no capture, no response, no memory side effect.
REQ-021 A new request SHALL be acceptable in the cycle immediately after dc_valid_o is high.
REQ-022 Store-then-load to the same address SHALL return the stored value (store commits before its response).

Reset
REQ-023 While rst_i = 1: state = IDLE, counter = 0, dc_valid_o = 0, dc_data_o = 0.
REQ-024 Reset mid-operation SHALL abandon the pending request: no response pulse, and a pending store SHALL NOT modify memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro SCRATCHPAD_ERR_EN defined: add output err_o (1 bit), sticky, set on a dropped request (REQ-020) or a misaligned half/word access (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0); cleared only by reset; access still performed per REQ-012.
REQ-027 Macro SCRATCHPAD_ERR_EN undefined: no err_o port; behaviour otherwise identical.

Verification
REQ-028 LATENCY=2: SW addr 0x10 data 0xDEADBEEF at cycle 0 -> dc_valid_o pulse at cycle 2, dc_data_o = 0; then LW 0x10 -> 0xDEADBEEF two cycles after acceptance.
REQ-029 After REQ-028: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-030 SB addr 0x11 data 0x00000055 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
REQ-031 Second dc_valid_i pulse one cycle after an accepted request -> exactly one response; memory unaffected by second request; err_o = 1 when SCRATCHPAD_ERR_EN defined.
REQ-032 SW addr 0x20 data 0x12345678 then rst_i pulsed the cycle after acceptance -> no dc_valid_o; LW 0x20 returns prior contents, not 0x12345678.
REQ-033 DEPTH_WORDS=1024: SW addr 0x1004 data 0xA5A5A5A5 -> LW 0x0004 returns 0xA5A5A5A5 (wrap-around).
